fetch_stage: RTL

- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage.
- Owns the 32-bit PC and boots it from instruction memory words 0/1.
- Applies redirects from jumps, PC pops and reload requests, and honours stall/flush from decode.
- Tags the second word of two-word LDM instructions so decode treats it as immediate data, not as an opcode.

---
 rtl/fetch_stage_pkg.sv | 14 +
 rtl/fetch_stage_if_id_reg.sv | 37 +++
 rtl/fetch_stage.sv | 119 +++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Constants and types shared by the fetch and decode stages.
package fetch_stage_pkg;

    localparam int          PC_W     = 32;
    localparam logic [4:0]  LDM_OPC  = 5'b11001;
    localparam logic [15:0] NOP_WORD = 16'h0000;

    typedef enum logic [1:0] {
        BOOT_HI = 2'd0,
        BOOT_LO = 2'd1,
        RUN     = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: bubble insert has priority over stall hold.
module if_id_reg #(
    parameter logic [15:0] BUBBLE_WORD = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bubble,
    input  logic        hold,
    input  logic [15:0] instr_d,
    input  logic [31:0] pc_next_d,
    input  logic        ldm_d,
    output logic [15:0] if_instr,
    output logic [31:0] if_pc_next,
    output logic        if_ldm_value,
    output logic        if_valid
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_instr     <= BUBBLE_WORD;
            if_pc_next   <= '0;
            if_ldm_value <= 1'b0;
            if_valid     <= 1'b0;
        end else if (bubble) begin
            if_instr     <= BUBBLE_WORD;
            if_pc_next   <= '0;
            if_ldm_value <= 1'b0;
            if_valid     <= 1'b0;
        end else if (!hold) begin
            if_instr     <= instr_d;
            if_pc_next   <= pc_next_d;
            if_ldm_value <= ldm_d;
            if_valid     <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: boots the PC from memory words 0/1, applies redirects,
// and tags the immediate word that follows an LDM opcode.
module fetch_stage #(
    parameter int          ADDR_W   = 20,
    parameter logic [4:0]  LDM_OPC  = fetch_stage_pkg::LDM_OPC,
    parameter logic [15:0] NOP_WORD = fetch_stage_pkg::NOP_WORD
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_data,
    input  logic              stall,
    input  logic              flush,
    input  logic              load_0_pc,
    input  logic              jmp_valid,
    input  logic [31:0]       jmp_pc,
    input  logic              pop_pc_valid,
    input  logic [31:0]       pop_pc,
    output logic [15:0]       if_instr,
    output logic [31:0]       if_pc_next,
    output logic              if_ldm_value,
    output logic              if_valid,
    output logic              booting
);
    import fetch_stage_pkg::*;

    fetch_state_e    state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt, pc_inc;
    logic [15:0]     boot_hi;
    logic            pend_imm, pend_nxt;
    logic            bubble, hold, accept, is_ldm;

    assign pc_inc = pc + 32'd1;
    assign is_ldm = (imem_data[15:11] == LDM_OPC);
    assign accept = !bubble && !hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= BOOT_HI;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT_HI: state_nxt = BOOT_LO;
            BOOT_LO: state_nxt = RUN;
            RUN:     state_nxt = load_0_pc ? BOOT_HI : RUN;
            default: state_nxt = BOOT_HI;
        endcase
    end

    // Boot states bubble IF/ID unconditionally and ignore decode's controls.
    always_comb begin
        imem_addr = pc[ADDR_W-1:0];
        booting   = 1'b0;
        bubble    = 1'b1;
        hold      = 1'b0;
        case (state)
            BOOT_HI: begin
                imem_addr = '0;
                booting   = 1'b1;
            end
            BOOT_LO: begin
                imem_addr = ADDR_W'(1);
                booting   = 1'b1;
            end
            RUN: begin
                bubble = load_0_pc || flush || pop_pc_valid || jmp_valid;
                hold   = stall;
            end
            default: ;
        endcase
    end

    always_comb begin
        pc_nxt = pc;
        if (state == BOOT_LO)
            pc_nxt = {boot_hi, imem_data};
        else if (state == RUN && !load_0_pc) begin
            if (pop_pc_valid)   pc_nxt = pop_pc;
            else if (jmp_valid) pc_nxt = jmp_pc;
            else if (!stall)    pc_nxt = pc_inc;
        end
    end

    // The word after an LDM opcode is data, even if its top bits look like LDM.
    always_comb begin
        pend_nxt = pend_imm;
        if (bubble)      pend_nxt = 1'b0;
        else if (accept) pend_nxt = is_ldm && !pend_imm;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= '0;
            boot_hi  <= '0;
            pend_imm <= 1'b0;
        end else begin
            pc       <= pc_nxt;
            pend_imm <= pend_nxt;
            if (state == BOOT_HI) boot_hi <= imem_data;
        end
    end

    if_id_reg #(.BUBBLE_WORD(NOP_WORD)) u_if_id (
        .clk          (clk),
        .rst          (rst),
        .bubble       (bubble),
        .hold         (hold),
        .instr_d      (imem_data),
        .pc_next_d    (pc_inc),
        .ldm_d        (pend_imm),
        .if_instr     (if_instr),
        .if_pc_next   (if_pc_next),
        .if_ldm_value (if_ldm_value),
        .if_valid     (if_valid)
    );

endmodule
